// File: rtl/r2mdc_stage_ctrl.sv
// Sequencer for one R2MDC FFT stage: delay-line pointers, commutator select, twiddle index, output strobes.
// Optional sticky protocol-error flag o_err_overrun when R2MDC_CTRL_ERR_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for in_valid & frame_start (pair 0 of a frame)
// S_RUN   | accepting pairs 0..NUM_PAIRS-1; in_valid=0 stalls
// S_DRAIN | flushing the last D samples out of the delay line
module r2mdc_stage_ctrl #(
   parameter int NUM_PAIRS = 32,
   parameter int STAGE     = 0,
   parameter int CNT_W     = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   input  logic             i_frame_start,
   output logic             o_dly_wr_en,
   output logic [CNT_W-1:0] o_dly_addr,
   output logic             o_cm_swap,
   output logic [CNT_W-1:0] o_tw_addr,
   output logic             o_out_valid,
   output logic             o_frame_done
`ifdef R2MDC_CTRL_ERR_EN
   ,
   output logic             o_err_overrun
`endif
);

   localparam int DEPTH    = NUM_PAIRS >> (STAGE + 1);
   localparam int SWAP_BIT = CNT_W - 1 - STAGE;
   localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] L_DLAST = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] L_PLAST = CNT_W'(NUM_PAIRS - 1);
   localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_wptr;
   logic [CNT_W-1:0] r_drain;
   logic [CNT_W-1:0] r_emit;

   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_drain_step;
   logic             w_adv;
   logic             w_emit;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_wptr_nxt;
   logic [CNT_W-1:0] w_drain_nxt;
   logic [CNT_W-1:0] w_emit_nxt;

   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_drain_step = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_in_valid && i_frame_start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (i_in_valid) begin
               w_accept = 1'b1;
               if (r_cnt == L_PLAST) w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (i_in_valid && i_frame_start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_drain_step = 1'b1;
               if (r_drain <= L_ONE) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_adv = w_accept | w_drain_step;
      // A new frame's early pairs push out whatever the previous frame left in the delay line.
      w_emit = w_drain_step | (w_accept & ((r_cnt >= L_DEPTH) | (r_drain != '0)));

      w_cnt_nxt  = w_accept ? (r_cnt + L_ONE) : r_cnt;
      w_wptr_nxt = r_wptr;
      if (w_adv) w_wptr_nxt = (r_wptr == L_DLAST) ? '0 : (r_wptr + L_ONE);

      w_drain_nxt = r_drain;
      if (w_accept && (r_cnt == L_PLAST))  w_drain_nxt = L_DEPTH;
      else if (w_emit && (r_drain != '0)) w_drain_nxt = r_drain - L_ONE;

      w_emit_nxt = w_emit ? (r_emit + L_ONE) : r_emit;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_wptr       <= '0;
         r_drain      <= '0;
         r_emit       <= '0;
         o_dly_wr_en  <= 1'b0;
         o_dly_addr   <= '0;
         o_cm_swap    <= 1'b0;
         o_tw_addr    <= '0;
         o_out_valid  <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_wptr       <= w_wptr_nxt;
         r_drain      <= w_drain_nxt;
         r_emit       <= w_emit_nxt;
         o_dly_wr_en  <= w_adv;
         o_dly_addr   <= w_adv ? r_wptr : '0;
         o_cm_swap    <= w_emit & r_emit[SWAP_BIT];
         o_tw_addr    <= w_emit ? (r_emit << STAGE) : '0;
         o_out_valid  <= w_emit;
         o_frame_done <= w_emit & (r_emit == L_PLAST);
      end
   end

`ifdef R2MDC_CTRL_ERR_EN
   logic w_err;

   always_comb begin
      w_err = ((r_state == S_IDLE) && i_in_valid && !i_frame_start) ||
              ((r_state == S_RUN) && i_in_valid && i_frame_start && (r_cnt != '0));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)      o_err_overrun <= 1'b0;
      else if (w_err) o_err_overrun <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_r2mdc_stage_ctrl.sv
// Directed bench for r2mdc_stage_ctrl: STAGE=0 (D=16) frame/back-to-back/bubble runs, STAGE=4 (D=1) reset mid-frame.
module tb_r2mdc_stage_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, v0, fs0, wr0, sw0, ov0, fd0;
   logic [4:0] addr0, tw0;
   logic       rst4, v4, fs4, wr4, sw4, ov4, fd4;
   logic [4:0] addr4, tw4;
`ifdef R2MDC_CTRL_ERR_EN
   logic       err0, err4;
`endif

   int total = 0;
   int bad   = 0;

   r2mdc_stage_ctrl #(.NUM_PAIRS(32), .STAGE(0), .CNT_W(5)) dut0 (
      .i_clk(clk), .i_rst(rst0), .i_in_valid(v0), .i_frame_start(fs0),
      .o_dly_wr_en(wr0), .o_dly_addr(addr0), .o_cm_swap(sw0), .o_tw_addr(tw0),
      .o_out_valid(ov0), .o_frame_done(fd0)
`ifdef R2MDC_CTRL_ERR_EN
      , .o_err_overrun(err0)
`endif
   );

   r2mdc_stage_ctrl #(.NUM_PAIRS(32), .STAGE(4), .CNT_W(5)) dut4 (
      .i_clk(clk), .i_rst(rst4), .i_in_valid(v4), .i_frame_start(fs4),
      .o_dly_wr_en(wr4), .o_dly_addr(addr4), .o_cm_swap(sw4), .o_tw_addr(tw4),
      .o_out_valid(ov4), .o_frame_done(fd4)
`ifdef R2MDC_CTRL_ERR_EN
      , .o_err_overrun(err4)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single frame on dut0; optional bubble every 3rd cycle. acc counts delay-pointer steps.
   task automatic run_frame0(input string tag, input bit gaps);
      int  acc, c, nov, nfd, e;
      bit  v;
      acc = 0; c = 0; nov = 0; nfd = 0;
      while (acc < 48 && c < 200) begin
         v   = (acc < 32) && !(gaps && (c % 3 == 2));
         v0  = v;
         fs0 = v && (acc == 0 || acc == 5);
         tick();
         if (v || acc >= 32) begin
            chk({tag, "_wr"}, 32'(wr0), 1);
            chk({tag, "_addr"}, 32'(addr0), 32'(acc % 16));
            chk({tag, "_ov"}, 32'(ov0), 32'(acc >= 16));
            if (acc >= 16) begin
               e = acc - 16;
               chk({tag, "_tw"}, 32'(tw0), 32'(e));
               chk({tag, "_sw"}, 32'(sw0), 32'(e >= 16));
            end
            chk({tag, "_fd"}, 32'(fd0), 32'(acc == 47));
            acc++;
         end else begin
            chk({tag, "_bub_wr"}, 32'(wr0), 0);
            chk({tag, "_bub_ov"}, 32'(ov0), 0);
         end
         nov += int'(ov0);
         nfd += int'(fd0);
         c++;
      end
      v0 = 1'b0; fs0 = 1'b0;
      chk({tag, "_steps"}, 32'(acc), 48);
      tick();
      chk({tag, "_idle_wr"}, 32'(wr0), 0);
      chk({tag, "_idle_ov"}, 32'(ov0), 0);
      chk({tag, "_nov"}, 32'(nov), 32);
      chk({tag, "_nfd"}, 32'(nfd), 1);
   endtask

   initial begin
      int nov, nfd, fd_t1, fd_t2, e;

      rst0 = 1'b1; rst4 = 1'b1;
      v0 = 1'b1; fs0 = 1'b1; v4 = 1'b1; fs4 = 1'b1;
      repeat (3) tick();
      chk("rst_wr", 32'(wr0), 0);
      chk("rst_addr", 32'(addr0), 0);
      chk("rst_sw", 32'(sw0), 0);
      chk("rst_tw", 32'(tw0), 0);
      chk("rst_ov", 32'(ov0), 0);
      chk("rst_fd", 32'(fd0), 0);
      chk("rst4_ov", 32'(ov4), 0);
      chk("rst4_wr", 32'(wr4), 0);

      // in_valid without frame_start in IDLE must be ignored
      rst0 = 1'b0; rst4 = 1'b0;
      v0 = 1'b1; fs0 = 1'b0; v4 = 1'b0; fs4 = 1'b0;
      tick();
      tick();
      chk("idle_ign_wr", 32'(wr0), 0);
      chk("idle_ign_ov", 32'(ov0), 0);

      run_frame0("frame", 1'b0);

      // two frames back-to-back
      nov = 0; nfd = 0; fd_t1 = -1; fd_t2 = -1;
      for (int t = 0; t < 80; t++) begin
         v0  = (t < 64);
         fs0 = (t == 0) || (t == 32);
         tick();
         chk("b2b_wr", 32'(wr0), 1);
         chk("b2b_addr", 32'(addr0), 32'(t % 16));
         chk("b2b_ov", 32'(ov0), 32'(t >= 16));
         if (t >= 16) begin
            e = (t - 16) % 32;
            chk("b2b_tw", 32'(tw0), 32'(e));
            chk("b2b_sw", 32'(sw0), 32'(e >= 16));
         end
         chk("b2b_fd", 32'(fd0), 32'(t == 47 || t == 79));
         nov += int'(ov0);
         if (fd0 === 1'b1) begin
            nfd++;
            if (fd_t1 < 0) fd_t1 = t;
            else fd_t2 = t;
         end
      end
      v0 = 1'b0; fs0 = 1'b0;
      tick();
      chk("b2b_idle_ov", 32'(ov0), 0);
      chk("b2b_nov", 32'(nov), 64);
      chk("b2b_nfd", 32'(nfd), 2);
      chk("b2b_fd_gap", 32'(fd_t2 - fd_t1), 32);

      run_frame0("bubble", 1'b1);

      // D=1 stage: pairs 0..9 then reset at pair 10
      for (int k = 0; k < 10; k++) begin
         v4 = 1'b1; fs4 = (k == 0);
         tick();
         chk("s4_wr", 32'(wr4), 1);
         chk("s4_addr", 32'(addr4), 0);
         chk("s4_ov", 32'(ov4), 32'(k >= 1));
         if (k >= 1) begin
            e = k - 1;
            chk("s4_tw", 32'(tw4), 32'((e % 2) * 16));
            chk("s4_sw", 32'(sw4), 32'(e % 2));
         end
         chk("s4_fd", 32'(fd4), 0);
      end
      rst4 = 1'b1; v4 = 1'b1; fs4 = 1'b0;
      tick();
      chk("s4rst_wr", 32'(wr4), 0);
      chk("s4rst_addr", 32'(addr4), 0);
      chk("s4rst_sw", 32'(sw4), 0);
      chk("s4rst_tw", 32'(tw4), 0);
      chk("s4rst_ov", 32'(ov4), 0);
      chk("s4rst_fd", 32'(fd4), 0);
      rst4 = 1'b0; v4 = 1'b1; fs4 = 1'b1;
      tick();
      chk("s4new0_wr", 32'(wr4), 1);
      chk("s4new0_ov", 32'(ov4), 0);
      fs4 = 1'b0;
      tick();
      chk("s4new1_ov", 32'(ov4), 1);
      chk("s4new1_tw", 32'(tw4), 0);
      chk("s4new1_sw", 32'(sw4), 0);
      tick();
      chk("s4new2_tw", 32'(tw4), 16);
      chk("s4new2_sw", 32'(sw4), 1);
      v4 = 1'b0;
      tick();
      chk("s4stall_ov", 32'(ov4), 0);
      chk("s4stall_wr", 32'(wr4), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
